uart_rx_buf: RTL and testbench
==============================

// Module: uart_rx_buf
// PURPOSE
//  Standalone buffered UART receiver: the host-side receive end of the link driven by
//  our uart transmitter. Oversamples rin with a phase-accumulator tick, majority-votes
//  each bit and checks framing. Hands bytes out through a one-entry holding register
//  with a valid/accept handshake. Sits between the pad synchroniser and consumer logic.
// PARAMETERS
//  Width       8  phase accumulator width; tick when accumulator carries
//  Incr        1  accumulator increment; tick rate = clk*Incr/2^Width
//  Oversample  8  ticks per bit period; even, >=4
// PORTS
//  clk        in   1  single clock, all logic posedge
//  reset      in   1  asynchronous, active-low (0 = in reset)
//  rin        in   1  serial line (async); idle 0, start 1, LSB first, stop 0
//  dout       out  8  received byte, stable while valid=1
//  valid      out  1  dout holds an unconsumed byte
//  accept     in   1  consumer takes dout on clk where valid&&accept
//  frame_err  out  1  1-clk pulse: stop bit sampled 1, byte discarded
//  overrun    out  1  1-clk pulse: byte completed while holding reg full, new byte dropped
//  busy       out  1  state != IDLE
// BEHAVIOUR
//  Reset: dout=0, valid=0, frame_err=0, overrun=0, busy=1 (state WAIT_IDLE), sync
//   flops=0, accumulator=0, counters=0. Async assert at any time aborts a frame.
//  rin passes a 2-flop synchroniser; all decisions use synced value s.
//  tick: 1-clk enable on accumulator carry; free-running, never re-phased.
//  FSM, advanced only on tick (except handshake/outputs, every clk):
//   WAIT_IDLE: s==0 on tick -> IDLE. Used after reset and after frame error.
//   IDLE: s==1 on tick -> START, tick counter cnt=0.
//   START: at cnt=Oversample/2 take majority of s at cnt-1,cnt,cnt+1 (vote done at cnt+1);
//    vote 0 -> IDLE (glitch, no output); vote 1 -> DATA, bit=0, cnt restarts at mid-bit.
//   DATA: every Oversample ticks from mid-start, 3-sample majority around mid-bit shifts
//    into shift[7] (LSB first, right shift); after bit 7 -> STOP.
//   STOP: majority at mid-stop. 0 -> deliver, IDLE. 1 -> frame_err pulse, WAIT_IDLE.
//  Delivery (clk after STOP vote):
//   valid==0, or valid&&accept same clk -> dout<=shift, valid<=1, no overrun.
//   valid&&!accept -> dout unchanged, overrun pulse, new byte lost.
//  accept with valid=0 ignored. valid falls clk after valid&&accept unless reloaded.
//  Latency: valid rises 1 clk after the tick of the final stop-bit vote sample.
//  Back-to-back frames: IDLE re-arms immediately after STOP; next start bit may follow
//   stop directly.
//  Counters: cnt width clog2(Oversample)+1, wraps only by explicit reset in FSM.
// STRUCTURE
//  Shared include uart_defs.vh: line polarity constants (UART_IDLE_LVL=0,
//   UART_START_LVL=1, UART_STOP_LVL=0), FSM state encodings, data width 8.
//  Sub-module uart_baud_tick (Width, Incr -> tick), reused by the transmitter.
//  Top: synchroniser, FSM+vote+shift, holding register/handshake.
// TESTING (Width=2, Incr=1, Oversample=4: tick every 4 clk, bit = 16 clk)
//  1 reset low mid-frame, release, rin=0 -> valid=0, frame_err=0, busy drops after idle seen.
//  2 send 8'hA9 framed, accept=1 -> valid pulses once, dout=8'hA9, no error pulses.
//  3 send 8'h99 then 8'hB1 back-to-back, accept=0 -> dout=8'h99 held, one overrun pulse;
//    assert accept -> valid falls next clk.
//  4 send 8'hEA with stop=1 -> one frame_err pulse, valid stays 0; rin->0 then 8'h5A
//    received correctly.
//  5 rin=1 for 4 clk (<half bit) -> returns IDLE, no valid, no errors.
//  6 accept and completion of 8'h3C on same clk with 8'h99 held -> dout=8'h3C, valid=1,
//    overrun=0.

Source files
------------

// File: rtl/uart_rx_buf_pkg.sv
// Shared definitions for the buffered UART receiver: line polarities, data width,
// receiver FSM states and the 3-sample majority vote.
package uart_rx_buf_pkg;

  localparam logic UART_IDLE_LVL  = 1'b0;
  localparam logic UART_START_LVL = 1'b1;
  localparam logic UART_STOP_LVL  = 1'b0;
  localparam int   DATA_W         = 8;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_buf_baud_tick.sv
// Free-running phase accumulator; emits a one-clock tick on every carry out.
module uart_rx_buf_baud_tick #(
  parameter int Width = 8,
  parameter int Incr  = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam logic [Width:0] IncrW = (Width + 1)'(Incr);

  logic [Width-1:0] r_acc;
  logic             r_tick;
  logic [Width:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + IncrW;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_acc  <= w_sum[Width-1:0];
      r_tick <= w_sum[Width];
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_buf.sv
// Buffered UART receiver: pad synchroniser, oversampling FSM with majority vote,
// and a one-entry holding register with a valid/accept handshake.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int Width      = 8,
  parameter int Incr       = 1,
  parameter int Oversample = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rin,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_valid,
  input  logic              i_accept,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int              CntW   = $clog2(Oversample) + 1;
  localparam logic [CntW-1:0] Last   = CntW'(Oversample - 1);
  localparam logic [CntW-1:0] Half   = CntW'(Oversample / 2);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Oversample / 2 - 1);
  localparam logic [CntW-1:0] HalfP1 = CntW'(Oversample / 2 + 1);

  logic              w_tick;
  logic              r_sync1, r_sync2, w_s;
  rx_state_e         r_state, w_stateNext;
  logic [CntW-1:0]   r_cnt, w_cntNext, w_pos;
  logic [1:0]        r_samp, w_sampNext;
  logic [DATA_W-1:0] r_shift, w_shiftNext;
  logic [2:0]        r_bit, w_bitNext;
  logic              w_vote, w_deliver, w_frameErr;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid, r_frameErr, r_overrun;

  uart_rx_buf_baud_tick #(.Width(Width), .Incr(Incr)) u_baud (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_rin;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_WAIT_IDLE;
      r_cnt   <= '0;
      r_samp  <= '0;
      r_shift <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_samp  <= w_sampNext;
      r_shift <= w_shiftNext;
      r_bit   <= w_bitNext;
    end
  end

  // The start-detect tick is bit position 0; every bit votes on positions Half-1..Half+1.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_sampNext  = r_samp;
    w_shiftNext = r_shift;
    w_bitNext   = r_bit;
    w_deliver   = 1'b0;
    w_frameErr  = 1'b0;
    w_pos       = (r_cnt == Last) ? '0 : r_cnt + 1'b1;
    w_vote      = maj3(r_samp[1], r_samp[0], w_s);
    if (w_tick) begin
      unique case (r_state)
        S_WAIT_IDLE: begin
          if (w_s == UART_IDLE_LVL) w_stateNext = S_IDLE;
        end
        S_IDLE: begin
          if (w_s == UART_START_LVL) begin
            w_stateNext = S_START;
            w_cntNext   = '0;
          end
        end
        S_START, S_DATA, S_STOP: begin
          w_cntNext = w_pos;
          if (w_pos == HalfM1) w_sampNext[1] = w_s;
          if (w_pos == Half)   w_sampNext[0] = w_s;
          if (w_pos == HalfP1) begin
            if (r_state == S_START) begin
              if (w_vote == UART_START_LVL) begin
                w_stateNext = S_DATA;
                w_bitNext   = '0;
              end else begin
                w_stateNext = S_IDLE;
              end
            end else if (r_state == S_DATA) begin
              w_shiftNext = {w_vote, r_shift[DATA_W-1:1]};
              w_bitNext   = r_bit + 3'd1;
              if (r_bit == 3'd7) w_stateNext = S_STOP;
            end else if (w_vote == UART_STOP_LVL) begin
              w_deliver   = 1'b1;
              w_stateNext = S_IDLE;
            end else begin
              w_frameErr  = 1'b1;
              w_stateNext = S_WAIT_IDLE;
            end
          end
        end
        default: w_stateNext = S_WAIT_IDLE;
      endcase
    end
  end

  // A completed byte may replace the held one only if it is being taken this clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_frameErr <= w_frameErr;
      r_overrun  <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || i_accept) begin
          r_dout  <= w_shiftNext;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dout      = r_dout;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frameErr;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf with Width=2, Incr=1, Oversample=4 (tick every 4 clk,
// one bit = 16 clk); frames are launched on a fixed tick phase.
module tb_uart_rx_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rin = 1'b0;
  logic       accept = 1'b0;
  logic [7:0] dout;
  logic       valid, frameErr, overrun, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int validRises = 0, validFalls = 0, frameErrs = 0, overruns = 0, busyRises = 0;
  logic [7:0] lastDout = 8'h00;
  logic prevValid = 1'b0, prevBusy = 1'b0;
  logic accLevel = 1'b0;

  int bRise, bFall, bFerr, bOvr, bBusy;

  always #5 clk = ~clk;

  uart_rx_buf #(.Width(2), .Incr(1), .Oversample(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rin       (rin),
    .o_dout      (dout),
    .o_valid     (valid),
    .i_accept    (accept),
    .o_frame_err (frameErr),
    .o_overrun   (overrun),
    .o_busy      (busy)
  );

  // Posedge count since reset release; ticks land on edges where cyc % 4 == 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #2;
    if (valid && !prevValid) begin
      validRises++;
      lastDout = dout;
    end
    if (!valid && prevValid) validFalls++;
    if (busy && !prevBusy) busyRises++;
    if (frameErr) frameErrs++;
    if (overrun) overruns++;
    prevValid = valid;
    prevBusy  = busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic snapshot();
    bRise = validRises;
    bFall = validFalls;
    bFerr = frameErrs;
    bOvr  = overruns;
    bBusy = busyRises;
  endtask

  // Called at a negedge; slot i drives the line ahead of posedge n+i, and the stop
  // vote (and any delivery) happens on posedge n+158.
  task automatic applyStimulus(input logic [7:0] data, input logic stopLvl, input int accIdx);
    while (cyc % 4 != 2) @(negedge clk);
    for (int i = 0; i < 160; i++) begin
      if (i < 16)       rin = 1'b1;
      else if (i < 144) rin = data[(i - 16) / 16];
      else              rin = stopLvl;
      accept = accLevel | (i == accIdx);
      @(negedge clk);
    end
    accept = accLevel;
  endtask

  task automatic waitIdle(input int maxClk, input string tag);
    int n;
    n = 0;
    while (busy && n < maxClk) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", {24'd0, dout}, 32'h00);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frameErr}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b1;
    waitIdle(40, "rst_idle");

    // 1: reset in the middle of a frame
    rin = 1'b1; repeat (20) @(negedge clk);
    rin = 1'b0; repeat (12) @(negedge clk);
    rin = 1'b1; repeat (10) @(negedge clk);
    checkOutput("t1_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t1_rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("t1_rst_valid", {31'd0, valid}, 32'd0);
    rin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    snapshot();
    waitIdle(40, "t1_idle");
    checkOutput("t1_valid", {31'd0, valid}, 32'd0);
    checkOutput("t1_ferr_cnt", frameErrs - bFerr, 32'd0);

    // 2: single byte with accept held high
    snapshot();
    accLevel = 1'b1;
    accept = 1'b1;
    applyStimulus(8'hA9, 1'b0, -1);
    repeat (4) @(negedge clk);
    checkOutput("t2_rises", validRises - bRise, 32'd1);
    checkOutput("t2_dout", {24'd0, lastDout}, 32'hA9);
    checkOutput("t2_valid_cleared", {31'd0, valid}, 32'd0);
    checkOutput("t2_ferr_cnt", frameErrs - bFerr, 32'd0);
    checkOutput("t2_ovr_cnt", overruns - bOvr, 32'd0);
    accLevel = 1'b0;
    accept = 1'b0;

    // 3: back-to-back frames while the holding register is full
    snapshot();
    applyStimulus(8'h99, 1'b0, -1);
    applyStimulus(8'hB1, 1'b0, -1);
    repeat (4) @(negedge clk);
    checkOutput("t3_rises", validRises - bRise, 32'd1);
    checkOutput("t3_valid", {31'd0, valid}, 32'd1);
    checkOutput("t3_dout", {24'd0, dout}, 32'h99);
    checkOutput("t3_ovr_cnt", overruns - bOvr, 32'd1);
    checkOutput("t3_ferr_cnt", frameErrs - bFerr, 32'd0);
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
    checkOutput("t3_valid_fall", {31'd0, valid}, 32'd0);

    // 4: framing error, then recovery
    snapshot();
    applyStimulus(8'hEA, 1'b1, -1);
    rin = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t4_ferr_cnt", frameErrs - bFerr, 32'd1);
    checkOutput("t4_rises", validRises - bRise, 32'd0);
    checkOutput("t4_valid", {31'd0, valid}, 32'd0);
    waitIdle(40, "t4_idle");
    snapshot();
    accLevel = 1'b1;
    accept = 1'b1;
    applyStimulus(8'h5A, 1'b0, -1);
    repeat (4) @(negedge clk);
    checkOutput("t4_rx_rises", validRises - bRise, 32'd1);
    checkOutput("t4_rx_dout", {24'd0, lastDout}, 32'h5A);
    checkOutput("t4_rx_ferr", frameErrs - bFerr, 32'd0);
    accLevel = 1'b0;
    accept = 1'b0;

    // 5: short glitch shorter than half a bit
    snapshot();
    while (cyc % 4 != 2) @(negedge clk);
    rin = 1'b1;
    repeat (4) @(negedge clk);
    rin = 1'b0;
    waitIdle(40, "t5_idle");
    repeat (20) @(negedge clk);
    checkOutput("t5_busy_rises", busyRises - bBusy, 32'd1);
    checkOutput("t5_rises", validRises - bRise, 32'd0);
    checkOutput("t5_ferr_cnt", frameErrs - bFerr, 32'd0);
    checkOutput("t5_ovr_cnt", overruns - bOvr, 32'd0);

    // 6: accept lands on the same clock as the next byte completes
    applyStimulus(8'h99, 1'b0, -1);
    repeat (4) @(negedge clk);
    checkOutput("t6_hold_valid", {31'd0, valid}, 32'd1);
    checkOutput("t6_hold_dout", {24'd0, dout}, 32'h99);
    snapshot();
    applyStimulus(8'h3C, 1'b0, 158);
    repeat (4) @(negedge clk);
    checkOutput("t6_dout", {24'd0, dout}, 32'h3C);
    checkOutput("t6_valid", {31'd0, valid}, 32'd1);
    checkOutput("t6_ovr_cnt", overruns - bOvr, 32'd0);
    checkOutput("t6_no_gap", validFalls - bFall, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
